// File: rtl/matmul_tile_engine.sv
// matmul_tile_engine
//   Outer-product matrix-multiply tile engine. Each accepted beat carries one
//   column a_k of A (M elements) and one row b_k of B (N elements); the engine
//   accumulates C += outer(a_k, b_k) over INNER_DIMENSION beats, then drains
//   C one row per handshake after fixed-point rounding, optional ReLU and
//   saturation.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    global enable, 0 freezes every register
//   flush                 synchronous abort of the current tile
//   relu_en               ReLU mode, latched with the first beat of a tile
//   in_valid / in_ready   input beat handshake
//   input_w               A column vector, M x WIDTH_A, element 0 at LSBs
//   input_n               B row vector,    N x WIDTH_B, element 0 at LSBs
//   out_valid / out_ready output row handshake
//   out_row               converted C row, N x WIDTH_OUT
//   out_row_idx           row index of out_row
//   out_last              out_row is the last row of the tile
//   busy                  engine is not idle
//   tile_done             one-cycle pulse after the last row transfers
//
// State table
//   S_IDLE  | waiting for the first beat of a tile
//   S_ACCUM | accumulating beats 1 .. INNER_DIMENSION-1
//   S_DRAIN | presenting converted rows to the output handshake

module matmul_tile_engine #(
   parameter int WIDTH_A         = 16,
   parameter int FRAC_WIDTH_A    = 8,
   parameter int WIDTH_B         = 16,
   parameter int FRAC_WIDTH_B    = 8,
   parameter int WIDTH_OUT       = 16,
   parameter int FRAC_WIDTH_OUT  = 8,
   parameter int CHUNK_SIZE      = 2,
   parameter int NUM_CORES_A     = 2,
   parameter int NUM_CORES_B     = 1,
   parameter int INNER_DIMENSION = 4,
   localparam int M     = NUM_CORES_A * CHUNK_SIZE,
   localparam int N     = NUM_CORES_B * CHUNK_SIZE,
   localparam int ROW_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   flush,
   input  logic                   relu_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH_A*M-1:0]   input_w,
   input  logic [WIDTH_B*N-1:0]   input_n,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH_OUT*N-1:0] out_row,
   output logic [ROW_W-1:0]       out_row_idx,
   output logic                   out_last,
   output logic                   busy,
   output logic                   tile_done
);

   localparam int ACC_W = WIDTH_A + WIDTH_B + $clog2(INNER_DIMENSION) + 1;
   localparam int SHIFT = FRAC_WIDTH_A + FRAC_WIDTH_B - FRAC_WIDTH_OUT;
   localparam int K_W   = $clog2(INNER_DIMENSION + 1);

   localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - WIDTH_OUT){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

   if (FRAC_WIDTH_A + FRAC_WIDTH_B <= FRAC_WIDTH_OUT) begin : g_bad_frac
      $error("matmul_tile_engine: FRAC_WIDTH_A+FRAC_WIDTH_B must exceed FRAC_WIDTH_OUT");
   end

   if (INNER_DIMENSION < 1) begin : g_bad_inner
      $error("matmul_tile_engine: INNER_DIMENSION must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [K_W-1:0]            r_k;
   logic [ROW_W-1:0]          r_row;
   logic                      r_relu;
   logic                      r_tile_done;
   logic signed [ACC_W-1:0]   r_acc  [M][N];
   logic signed [ACC_W-1:0]   w_prod [M][N];
   logic                      w_beat;
   logic                      w_xfer;
   logic                      w_last_k;
   logic                      w_last_row;

   // Round half-up, optional ReLU, then saturate; one extra bit keeps the
   // rounding add from wrapping.
   function automatic logic [WIDTH_OUT-1:0] f_convert(input logic signed [ACC_W-1:0] acc,
                                                      input logic relu);
      logic signed [ACC_W:0] v;
      v = (ACC_W + 1)'(acc) + RND;
      v = v >>> SHIFT;
      if (relu && v[ACC_W]) begin
         v = '0;
      end
      if (v > OUT_MAX) begin
         return OUT_MAX[WIDTH_OUT-1:0];
      end else if (v < OUT_MIN) begin
         return OUT_MIN[WIDTH_OUT-1:0];
      end
      return v[WIDTH_OUT-1:0];
   endfunction

   assign in_ready   = rst_n & en & ~flush & ((r_state == S_IDLE) | (r_state == S_ACCUM));
   assign out_valid  = en & (r_state == S_DRAIN);
   assign busy       = (r_state != S_IDLE);
   assign tile_done  = r_tile_done;
   assign out_row_idx = r_row;
   assign w_last_k   = (r_k == K_W'(INNER_DIMENSION - 1));
   assign w_last_row = (r_row == ROW_W'(M - 1));
   assign out_last   = (r_state == S_DRAIN) & w_last_row;

   assign w_beat = in_valid & in_ready;
   // flush wins over a simultaneous transfer
   assign w_xfer = out_valid & out_ready & ~flush;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            w_prod[i][j] = ACC_W'($signed(input_w[i*WIDTH_A +: WIDTH_A]))
                         * ACC_W'($signed(input_n[j*WIDTH_B +: WIDTH_B]));
         end
      end
   end

   always_comb begin
      out_row = '0;
      for (int j = 0; j < N; j++) begin
         out_row[j*WIDTH_OUT +: WIDTH_OUT] = f_convert(r_acc[r_row][j], r_relu);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (en) begin
         if (flush) begin
            w_state_nxt = S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_beat) begin
                     w_state_nxt = (INNER_DIMENSION == 1) ? S_DRAIN : S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  if (w_beat && w_last_k) begin
                     w_state_nxt = S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (w_xfer && w_last_row) begin
                     w_state_nxt = S_IDLE;
                  end
               end
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k         <= '0;
         r_row       <= '0;
         r_relu      <= 1'b0;
         r_tile_done <= 1'b0;
         for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
               r_acc[i][j] <= '0;
            end
         end
      end else if (en) begin
         r_tile_done <= 1'b0;
         if (flush) begin
            r_k   <= '0;
            r_row <= '0;
         end else begin
            if (w_beat) begin
               if (r_state == S_IDLE) begin
                  // first beat overwrites, so an aborted tile never leaks in
                  for (int i = 0; i < M; i++) begin
                     for (int j = 0; j < N; j++) begin
                        r_acc[i][j] <= w_prod[i][j];
                     end
                  end
                  r_relu <= relu_en;
                  r_k    <= K_W'(1);
               end else begin
                  for (int i = 0; i < M; i++) begin
                     for (int j = 0; j < N; j++) begin
                        r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                     end
                  end
                  r_k <= r_k + K_W'(1);
               end
            end
            if (w_xfer) begin
               if (w_last_row) begin
                  r_row       <= '0;
                  r_tile_done <= 1'b1;
               end else begin
                  r_row <= r_row + ROW_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed bench for matmul_tile_engine with default parameters
// (M = 4, N = 2, INNER_DIMENSION = 4). Expected rows come from a
// 64-bit arithmetic model filled beat by beat and queued on the final beat.

module tb_matmul_tile_engine;

   localparam int WA = 16;
   localparam int WB = 16;
   localparam int WO = 16;
   localparam int M  = 4;
   localparam int N  = 2;
   localparam int K  = 4;
   localparam int RW = 2;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            en        = 1'b0;
   logic            flush     = 1'b0;
   logic            relu_en   = 1'b0;
   logic            in_valid  = 1'b0;
   logic            out_ready = 1'b0;
   logic [WA*M-1:0] input_w   = '0;
   logic [WB*N-1:0] input_n   = '0;
   logic            in_ready;
   logic            out_valid;
   logic [WO*N-1:0] out_row;
   logic [RW-1:0]   out_row_idx;
   logic            out_last;
   logic            busy;
   logic            tile_done;

   typedef struct packed {
      logic [WO*N-1:0] row;
      logic [RW-1:0]   idx;
      logic            last;
   } exp_t;

   exp_t   sb_q[$];
   longint m_acc [M][N];
   logic   m_relu;
   int     n_cmp  = 0;
   int     n_fail = 0;
   int     n_done = 0;

   matmul_tile_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .flush       (flush),
      .relu_en     (relu_en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .input_w     (input_w),
      .input_n     (input_n),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_row_idx (out_row_idx),
      .out_last    (out_last),
      .busy        (busy),
      .tile_done   (tile_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tile_done === 1'b1) n_done++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WO-1:0] conv(input longint acc, input logic relu);
      longint t;
      t = (acc + 64'sd128) >>> 8;
      if (relu && t < 0) t = 0;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      return t[WO-1:0];
   endfunction

   function automatic logic [WA*M-1:0] rep_a(input logic [WA-1:0] v);
      return {M{v}};
   endfunction

   function automatic logic [WB*N-1:0] rep_b(input logic [WB-1:0] v);
      return {N{v}};
   endfunction

   function automatic logic [WA*M-1:0] rand_a();
      logic [WA*M-1:0] v;
      for (int i = 0; i < M; i++) v[i*WA +: WA] = 16'($urandom_range(0, 4095)) - 16'd2048;
      return v;
   endfunction

   function automatic logic [WB*N-1:0] rand_b();
      logic [WB*N-1:0] v;
      for (int j = 0; j < N; j++) v[j*WB +: WB] = 16'($urandom_range(0, 4095)) - 16'd2048;
      return v;
   endfunction

   task automatic send_beat(input logic [WA*M-1:0] a, input logic [WB*N-1:0] b, input int kidx);
      int waitc;
      logic signed [WA-1:0] ai;
      logic signed [WB-1:0] bj;
      exp_t e;
      @(negedge clk);
      input_w  = a;
      input_n  = b;
      in_valid = 1'b1;
      #1;
      waitc = 0;
      while (in_ready !== 1'b1 && waitc < 50) begin
         @(negedge clk); #1;
         waitc++;
      end
      chk("beat_accept", in_ready, 1);
      if (in_ready !== 1'b1) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (kidx == 0) m_relu = relu_en;
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) begin
            ai = a[i*WA +: WA];
            bj = b[j*WB +: WB];
            if (kidx == 0) m_acc[i][j] = longint'(ai) * longint'(bj);
            else           m_acc[i][j] = m_acc[i][j] + longint'(ai) * longint'(bj);
         end
      end
      if (kidx == K - 1) begin
         for (int r = 0; r < M; r++) begin
            for (int j = 0; j < N; j++) e.row[j*WO +: WO] = conv(m_acc[r][j], m_relu);
            e.idx  = RW'(r);
            e.last = (r == M - 1);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic run_tile(input logic [WA-1:0] av, input logic [WB-1:0] bv,
                           input logic relu0, input logic relu_rest);
      relu_en = relu0;
      for (int k = 0; k < K; k++) begin
         if (k == 1) relu_en = relu_rest;
         send_beat(rep_a(av), rep_b(bv), k);
      end
   endtask

   task automatic collect(input int stall_at, input int stall_cycles);
      exp_t e;
      int   waitc;
      int   done0;
      done0 = n_done;
      for (int r = 0; r < M; r++) begin
         @(negedge clk); #1;
         waitc = 0;
         while (out_valid !== 1'b1 && waitc < 100) begin
            @(negedge clk); #1;
            waitc++;
         end
         chk("row_valid", out_valid, 1);
         if (out_valid !== 1'b1) return;
         n_cmp++;
         assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL row_expected: observed extra row idx %0d, expected none queued", out_row_idx);
         end
         if (sb_q.size() == 0) return;
         e = sb_q.pop_front();
         if (r == stall_at) begin
            for (int s = 0; s < stall_cycles; s++) begin
               chk("bp_idx", out_row_idx, e.idx);
               chk("bp_row", out_row, e.row);
               chk("bp_valid", out_valid, 1);
               chk("bp_in_ready", in_ready, 0);
               @(negedge clk); #1;
            end
         end
         chk("row_data", out_row, e.row);
         chk("row_idx", out_row_idx, e.idx);
         chk("row_last", out_last, e.last);
         chk("busy_drain", busy, 1);
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
      @(negedge clk); #1;
      chk("tile_done", tile_done, 1);
      chk("in_ready_after", in_ready, 1);
      chk("busy_after", busy, 0);
      @(negedge clk); #1;
      chk("tile_done_pulse", tile_done, 0);
      chk("done_count", n_done - done0, 1);
   endtask

   initial begin
      int d0;
      logic [WA*M-1:0] sa [K];
      logic [WB*N-1:0] sbv [K];

      // reset state
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tile_done", tile_done, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_row_idx", out_row_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      // basic tile: 4 x (1.0 * 0.5) = 2.0 -> 0x0200
      run_tile(16'h0100, 16'h0080, 1'b0, 1'b0);
      collect(-1, 0);

      // distinct element values
      relu_en = 1'b0;
      for (int k = 0; k < K; k++) send_beat(rand_a(), rand_b(), k);
      collect(-1, 0);

      // rounding and saturation
      run_tile(16'h0001, 16'h0020, 1'b0, 1'b0);
      collect(-1, 0);
      run_tile(16'h0001, 16'h0010, 1'b0, 1'b0);
      collect(-1, 0);
      run_tile(16'h7F00, 16'h7F00, 1'b0, 1'b0);
      collect(-1, 0);
      run_tile(16'h8000, 16'h7F00, 1'b0, 1'b0);
      collect(-1, 0);

      // ReLU off, then on at beat 0 and toggled off afterwards
      run_tile(16'hFF00, 16'h0100, 1'b0, 1'b0);
      collect(-1, 0);
      run_tile(16'hFF00, 16'h0100, 1'b1, 1'b0);
      collect(-1, 0);

      // backpressure at row 1 for 3 cycles
      run_tile(16'h0100, 16'h0080, 1'b0, 1'b0);
      collect(1, 3);

      // en stall between beats 1 and 2, and during drain
      relu_en = 1'b0;
      for (int k = 0; k < K; k++) begin
         sa[k]  = rand_a();
         sbv[k] = rand_b();
      end
      send_beat(sa[0], sbv[0], 0);
      send_beat(sa[1], sbv[1], 1);
      @(negedge clk);
      en = 1'b0; in_valid = 1'b1; input_w = sa[3]; input_n = sbv[3];
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
      @(negedge clk); #1;
      chk("stall_in_ready2", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0; en = 1'b1;
      send_beat(sa[2], sbv[2], 2);
      send_beat(sa[3], sbv[3], 3);
      @(negedge clk);
      en = 1'b0; out_ready = 1'b1;
      #1;
      chk("stall_out_valid", out_valid, 0);
      @(negedge clk); #1;
      chk("stall_out_valid2", out_valid, 0);
      out_ready = 1'b0; en = 1'b1;
      collect(-1, 0);

      // flush after beat 2, with a beat offered in the flush cycle
      send_beat(rep_a(16'h0300), rep_b(16'h0200), 0);
      send_beat(rep_a(16'h0300), rep_b(16'h0200), 1);
      send_beat(rep_a(16'h0300), rep_b(16'h0200), 2);
      d0 = n_done;
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("flush_busy", busy, 0);
      chk("flush_in_ready_after", in_ready, 1);
      chk("flush_out_valid", out_valid, 0);
      @(negedge clk); #1;
      chk("flush_no_done", n_done - d0, 0);
      relu_en = 1'b0;
      for (int k = 0; k < K; k++) send_beat(rand_a(), rand_b(), k);
      collect(-1, 0);

      // reset mid-tile after 2 beats
      send_beat(rep_a(16'h0100), rep_b(16'h0080), 0);
      send_beat(rep_a(16'h0100), rep_b(16'h0080), 1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_row", out_row, 0);
      chk("mid_rst_out_row_idx", out_row_idx, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_tile_done", tile_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_tile(16'h0100, 16'h0080, 1'b0, 1'b0);
      collect(-1, 0);

      chk("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
